// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC
// default, opcode constants and the branch-offset helper.
package inst_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_BEQ           = 6'b000100;

  // Word offset of a conditional branch, already scaled to bytes.
  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC selection: jump target, taken branch target, or PC+4.
module pc_next
  import inst_fetch_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  output logic [31:0] NextPC
);

  logic [31:0] w_pc4;
  logic        w_unusedOpcode;

  assign w_pc4          = PC + 32'd4;
  assign w_unusedOpcode = ^Instr[31:26];

  // Jump wins over a simultaneous branch; low bits stay word aligned.
  always_comb begin
    NextPC = w_pc4;
    if (Jump) begin
      NextPC = {w_pc4[31:28], Instr[25:0], 2'b00};
    end else if (Branch && Zero) begin
      NextPC = w_pc4 + branchOffset(Instr[15:0]);
    end
    NextPC[1:0] = 2'b00;
  end

endmodule

// File: rtl/inst_fetch.sv
// Two-state fetch/execute sequencer holding PC, the current instruction and
// the retired-instruction counter.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        Stall,
  input  logic [31:0] IMemRData,
  input  logic        IMemReady,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        InstrValid,
  output logic [31:0] RetiredCount
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_imemReq;
  logic        r_instrValid;
  logic [31:0] w_nextPc;

  pc_next u_pcNext (
    .PC     (r_pc),
    .Instr  (r_instr),
    .Branch (Branch),
    .Zero   (Zero),
    .Jump   (Jump),
    .NextPC (w_nextPc)
  );

  // Ready is only honoured while a request is outstanding, so a response
  // left over from before reset cannot be captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_instr      <= 32'h0;
      r_retired    <= 32'h0;
      r_imemReq    <= 1'b0;
      r_instrValid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_imemReq && IMemReady) begin
            r_instr      <= IMemRData;
            r_state      <= EXEC;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b1;
          end else begin
            r_imemReq <= 1'b1;
          end
        end
        EXEC: begin
          if (!Stall) begin
            r_pc         <= w_nextPc;
            r_retired    <= r_retired + 32'd1;
            r_state      <= FETCH;
            r_imemReq    <= 1'b1;
            r_instrValid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign IMemReq      = r_imemReq;
  assign IMemAddr     = r_pc;
  assign PC           = r_pc;
  assign Instr        = r_instr;
  assign OpCode       = r_instr[31:26];
  assign Funct        = r_instr[5:0];
  assign InstrValid   = r_instrValid;
  assign RetiredCount = r_retired;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: drives a scripted instruction memory and
// control flags, checking PC flow, handshake, stalls and reset behaviour.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic        Stall = 1'b0;
  logic [31:0] IMemRData = 32'h0;
  logic        IMemReady = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        InstrValid;
  logic [31:0] RetiredCount;

  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] expRetired = 32'h0;

  localparam logic [31:0] ADD    = 32'h0000_0020;
  localparam logic [31:0] BEQ_M2 = {OP_BEQ, 10'd0, 16'hFFFE};
  localparam logic [31:0] J_FAR  = {OP_J, 26'h3FF_FFFF};
  localparam logic [31:0] J_100  = {OP_J, 26'h000_0040};
  localparam logic [31:0] J_40   = {OP_J, 26'h000_0010};

  inst_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .Stall        (Stall),
    .IMemRData    (IMemRData),
    .IMemReady    (IMemReady),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .PC           (PC),
    .Instr        (Instr),
    .OpCode       (OpCode),
    .Funct        (Funct),
    .InstrValid   (InstrValid),
    .RetiredCount (RetiredCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One instruction end to end: optional memory wait, handshake, optional
  // stall in EXEC, then retirement with the given control flags.
  task automatic applyStimulus(input string tag, input logic [31:0] word,
                               input logic br, input logic z, input logic j,
                               input int waitCycles, input int stallCycles,
                               input logic [31:0] expAddr, input logic [31:0] expNext);
    checkOutput({tag, ".req"}, {31'd0, IMemReq}, 32'd1);
    checkOutput({tag, ".addr"}, IMemAddr, expAddr);
    for (int w = 0; w < waitCycles; w++) begin
      tick();
      checkOutput({tag, ".waitPc"}, PC, expAddr);
      checkOutput({tag, ".waitReq"}, {31'd0, IMemReq}, 32'd1);
      checkOutput({tag, ".waitValid"}, {31'd0, InstrValid}, 32'd0);
    end
    IMemReady = 1'b1;
    IMemRData = word;
    tick();
    IMemReady = 1'b0;
    IMemRData = 32'hDEAD_BEEF;
    checkOutput({tag, ".valid"}, {31'd0, InstrValid}, 32'd1);
    checkOutput({tag, ".instr"}, Instr, word);
    Branch = br;
    Zero   = z;
    Jump   = j;
    for (int s = 0; s < stallCycles; s++) begin
      Stall     = 1'b1;
      IMemReady = 1'b1;
      tick();
      checkOutput({tag, ".stallInstr"}, Instr, word);
      checkOutput({tag, ".stallPc"}, PC, expAddr);
      checkOutput({tag, ".stallRet"}, RetiredCount, expRetired);
      checkOutput({tag, ".stallValid"}, {31'd0, InstrValid}, 32'd1);
    end
    Stall     = 1'b0;
    IMemReady = 1'b0;
    tick();
    Branch = 1'b0;
    Zero   = 1'b0;
    Jump   = 1'b0;
    expRetired = expRetired + 32'd1;
    checkOutput({tag, ".nextPc"}, PC, expNext);
    checkOutput({tag, ".ret"}, RetiredCount, expRetired);
    checkOutput({tag, ".validOff"}, {31'd0, InstrValid}, 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".pc"}, PC, 32'h0);
    checkOutput({tag, ".instr"}, Instr, 32'h0);
    checkOutput({tag, ".ret"}, RetiredCount, 32'h0);
    checkOutput({tag, ".req"}, {31'd0, IMemReq}, 32'd0);
    checkOutput({tag, ".valid"}, {31'd0, InstrValid}, 32'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 checkResetState("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("firstReq", {31'd0, IMemReq}, 32'd1);
    checkOutput("firstAddr", IMemAddr, 32'h0);

    applyStimulus("add0", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h4);
    applyStimulus("add1", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'h4, 32'h8);
    checkOutput("opcode", {26'd0, OpCode}, 32'h0);
    checkOutput("funct", {26'd0, Funct}, 32'h20);
    applyStimulus("add2", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'h8, 32'hC);
    checkOutput("ret3", RetiredCount, 32'd3);

    applyStimulus("beqBack", BEQ_M2, 1'b1, 1'b1, 1'b0, 0, 0, 32'hC, 32'h8);
    applyStimulus("beqTaken", BEQ_M2, 1'b1, 1'b1, 1'b0, 0, 0, 32'h8, 32'h4);
    applyStimulus("add4", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'h4, 32'h8);
    applyStimulus("beqNot", BEQ_M2, 1'b1, 1'b0, 1'b0, 0, 0, 32'h8, 32'hC);
    applyStimulus("waitStall", ADD, 1'b0, 1'b0, 1'b0, 5, 3, 32'hC, 32'h10);
    applyStimulus("jFar", J_FAR, 1'b0, 1'b0, 1'b1, 0, 0, 32'h10, 32'h0FFF_FFFC);
    applyStimulus("addEdge", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0FFF_FFFC, 32'h1000_0000);
    applyStimulus("jOverBr", J_100, 1'b1, 1'b1, 1'b1, 0, 0, 32'h1000_0000, 32'h1000_0100);

    // Reset mid-fetch, then a stale ready must not be captured.
    #2 reset = 1'b1;
    expRetired = 32'h0;
    #1 checkResetState("rstFetch");
    @(posedge clk);
    #1;
    IMemReady = 1'b1;
    IMemRData = ADD;
    reset     = 1'b0;
    tick();
    IMemReady = 1'b0;
    checkOutput("lateReq", {31'd0, IMemReq}, 32'd1);
    checkOutput("lateValid", {31'd0, InstrValid}, 32'd0);
    checkOutput("lateInstr", Instr, 32'h0);

    applyStimulus("j40", J_40, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0, 32'h40);

    // Reset while executing at 0x40.
    IMemReady = 1'b1;
    IMemRData = ADD;
    tick();
    IMemReady = 1'b0;
    checkOutput("exec40Valid", {31'd0, InstrValid}, 32'd1);
    checkOutput("exec40Pc", PC, 32'h40);
    #2 reset = 1'b1;
    expRetired = 32'h0;
    #1 checkResetState("rstExec");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("refetchReq", {31'd0, IMemReq}, 32'd1);
    checkOutput("refetchAddr", IMemAddr, 32'h0);

    applyStimulus("beqWrap", BEQ_M2, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0, 32'hFFFF_FFFC);
    applyStimulus("addWrap", ADD, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC, 32'h0);
    checkOutput("ret2", RetiredCount, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port Branch, input, 1: branch instruction flag from control unit; sampled in EXEC only.
REQ-005 Port Zero, input, 1: ALU zero flag; sampled in EXEC only.
REQ-006 Port Jump, input, 1: jump flag from control unit; sampled in EXEC only.
REQ-007 Port Stall, input, 1: holds the current instruction in EXEC while high.
REQ-008 Port IMemRData, input, 32: instruction word returned by instruction memory.
REQ-009 Port IMemReady, input, 1: instruction memory data valid this cycle.
REQ-010 Port IMemReq, output, 1: fetch request to instruction memory.
REQ-011 Port IMemAddr, output, 32: fetch byte address, always equal to PC.
REQ-012 Port PC, output, 32: address of the current instruction.
REQ-013 Port Instr, output, 32: latched instruction word.
REQ-014 Port OpCode, output, 6: Instr[31:26], driven to the control unit.
REQ-015 Port Funct, output, 6: Instr[5:0], driven to the control unit.
REQ-016 Port InstrValid, output, 1: Instr/OpCode/Funct are valid for execution.
REQ-017 Port RetiredCount, output, 32: number of instructions that have left EXEC.

Function
REQ-018 FSM SHALL have two states: FETCH and EXEC.
REQ-019 FETCH: IMemReq=1 and InstrValid=0; when IMemReady=1, Instr <= IMemRData and the next state is EXEC.
REQ-020 FETCH with IMemReady=0 SHALL hold PC, IMemReq and Instr unchanged, with no timeout.
REQ-021 EXEC: IMemReq=0 and InstrValid=1; IMemReady SHALL be ignored.
REQ-022 EXEC with Stall=1 SHALL hold PC, Instr and RetiredCount, and remain in EXEC.
REQ-023 EXEC with Stall=0 SHALL load PC with NextPC, increment RetiredCount, and move to FETCH in one cycle.
REQ-024 PC4 = PC + 32'd4, modulo 2^32; wrap from 32'hFFFFFFFC to 0 SHALL NOT be flagged.
REQ-025 NextPC when Jump=1: {PC4[31:28], Instr[25:0], 2'b00}.
REQ-026 NextPC when Jump=0, Branch=1 and Zero=1: PC4 + (sign-extended Instr[15:0] << 2), modulo 2^32.
REQ-027 NextPC in all other cases: PC4.
REQ-028 Jump SHALL take priority over Branch when both are asserted.
REQ-029 PC[1:0] SHALL always be 2'b00; NextPC[1:0] SHALL be forced to 00.
REQ-030 Latency: an instruction SHALL be valid in EXEC one cycle after the IMemReady cycle.
REQ-031 Minimum issue interval: 2 cycles per instruction (zero-wait memory, no stall).
REQ-032 RetiredCount SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-033 reset=1 SHALL immediately set: state FETCH, PC=RESET_PC, Instr=0, RetiredCount=0, IMemReq=0, InstrValid=0.
REQ-034 reset asserted mid-fetch or mid-EXEC SHALL abandon the transaction; a late IMemReady SHALL be ignored.
REQ-035 First rising edge after deassertion: IMemReq=1 with IMemAddr=RESET_PC.

Structure
REQ-036 Shared package SHALL hold: FSM state encoding, RESET_PC default, OP_J=6'b000010, OP_BEQ=6'b000100.
REQ-037 Next-PC computation SHALL be a combinational sub-module pc_next (inputs PC, Instr, Branch, Zero, Jump; output NextPC).
REQ-038 All registers SHALL live in inst_fetch.

Verification
REQ-039 Reset, zero-wait memory returning 32'h00000020 (add) -> IMemAddr 0, then 4, then 8; OpCode=0, Funct=6'h20; RetiredCount=3 after 6 cycles.
REQ-040 PC=8, Instr=32'h1000FFFE (beq), Branch=1, Zero=1 -> NextPC=32'h00000004; same with Zero=0 -> 32'h0000000C.
REQ-041 PC=32'h10000000, Instr=32'h08000040, Jump=1, Branch=1 -> NextPC=32'h10000100.
REQ-042 IMemReady held low 5 cycles in FETCH -> PC stable, IMemReq=1, InstrValid=0; ready on cycle 6 -> EXEC next cycle.
REQ-043 Stall=1 for 3 EXEC cycles -> Instr, PC and RetiredCount unchanged; advance on first Stall=0 cycle.
REQ-044 reset asserted in EXEC at PC=32'h40 -> immediate PC=0, InstrValid=0; refetch from 0; PC=32'hFFFFFFFC plain instruction -> next PC=0.
